keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 5, sets the column dwell in clk cycles; 5 for simulation, 1200 for hardware; legal range 3..2^16-1.
REQ-002 clk  input  1  system clock; every flop is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 row_raw  input  4  raw keypad row lines, active-high (pulled down), asynchronous to clk.
REQ-005 button_pressed  input  1  debouncer busy flag; high means hold the current column.
REQ-006 col_drive  output  4  one-hot active-high column drive; bit i drives column i.
REQ-007 col_idx  output  2  binary index of the driven column, always consistent with col_drive.
REQ-008 q_row_keys  output  4  synchronized, settle-qualified row vector for the debouncer.

Function
REQ-009 The FSM SHALL have four states, COL0..COL3, with one state per driven column.
REQ-010 In state COLn: col_drive SHALL be one-hot at bit n, and col_idx SHALL equal n.
REQ-011 row_raw SHALL pass through a 2-flop synchronizer before any use; the latency is exactly 2 cycles.
REQ-012 A dwell counter SHALL count 0..SCAN_DIV-1 in each column; it clears to 0 on every column change.
REQ-013 When the counter is at SCAN_DIV-1 and button_pressed=0, the FSM SHALL advance on the next edge: COL0->COL1->COL2->COL3->COL0 (wrap-around).
REQ-014 While button_pressed=1, the FSM and col_drive SHALL hold, and the counter SHALL saturate at SCAN_DIV-1.
REQ-015 If button_pressed rises in the terminal-count cycle, hold SHALL take priority and no advance SHALL occur.
REQ-016 When button_pressed falls with the counter saturated, the advance SHALL occur on the first edge where button_pressed=0 is sampled.
REQ-017 q_row_keys SHALL be forced to 4'b0000 while the counter is below 2; this blanks stale rows from the previous column out of the synchronizer.
REQ-018 When the counter is 2 or above, q_row_keys SHALL equal the synchronizer output, with no further filtering.
REQ-019 Multiple simultaneous row bits SHALL pass through unchanged; resolving them is the debouncer's job.
REQ-020 q_row_keys, col_drive and col_idx SHALL all be registered outputs, with no combinational path from any input.
REQ-021 The counter width SHALL be 16 bits, with an unsigned compare against SCAN_DIV-1.

Reset
REQ-022 Assertion of reset (low) SHALL immediately force: state COL0, col_drive=4'b0001, col_idx=0, counter=0, both synchronizer stages=0, q_row_keys=0.
REQ-023 Reset asserted mid-dwell or during a hold SHALL discard the hold; scanning restarts at COL0 with a full dwell after deassertion.
REQ-024 The first advance after reset release SHALL occur SCAN_DIV cycles after the first active edge.

Structure
REQ-025 The column state enum and the constant SYNC_STAGES=2 SHALL reside in shared package keypad_pkg, together with the debouncer's types.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by width (4 here), with active-low async reset.
REQ-027 The FSM, counter and output qualification SHALL live in keypad_scanner.

Verification
REQ-028 Free-run: with SCAN_DIV=5, row_raw=0 and button_pressed=0, col_drive SHALL cycle 0001,0010,0100,1000,0001 every 5 cycles, and q_row_keys SHALL stay 0.
REQ-029 Key detect: with row_raw=4'b0100 held during COL2, q_row_keys SHALL be 0 for counter 0-1 and 4'b0100 from counter 2 on; it SHALL be 0 in the other columns.
REQ-030 Hold: set button_pressed=1 in COL1 at counter 1 and hold it 20 cycles; col_drive SHALL stay 0010 throughout; on release, COL2 SHALL be entered on the next edge.
REQ-031 Simultaneous: raise button_pressed in the COL3 terminal-count cycle; there SHALL be no wrap to COL0 until button_pressed=0.
REQ-032 Reset mid-op: assert reset low in COL2 during a hold; outputs SHALL go immediately to 0001/0/0; after release, the first advance SHALL occur after 5 cycles.
REQ-033 Async input: toggle row_raw between clock edges; q_row_keys SHALL change only 2 edges later and never glitch between edges.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad types: column states, synchronizer depth, debouncer types
package keypad_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_e;

    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_CHECK   = 2'd1,
        DB_PRESSED = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] row;
        logic [1:0] col;
    } key_code_t;

    // One-hot column drive pattern for a column state.
    function automatic logic [3:0] col_onehot(col_state_e s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad row/column signal bundle
interface keypad_scanner_if;
    logic [3:0] row_raw;
    logic       button_pressed;
    logic [3:0] col_drive;
    logic [1:0] col_idx;
    logic [3:0] q_row_keys;

    // Scanner side: drives columns, consumes rows and the debouncer busy flag.
    modport master (
        input  row_raw,
        input  button_pressed,
        output col_drive,
        output col_idx,
        output q_row_keys
    );

    // Keypad/debouncer side.
    modport slave (
        output row_raw,
        output button_pressed,
        input  col_drive,
        input  col_idx,
        input  q_row_keys
    );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// rtl/keypad_scanner_sync_2ff.sv - multi-bit flop-chain synchronizer for async row inputs
module sync_2ff
    import keypad_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the asynchronous input through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning keypad front end with dwell counter and row blanking
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kif
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(2);

    col_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_drive_q, col_drive_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic             qual_q, qual_d;
    logic             advance;
    logic [3:0]       row_sync;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (kif.row_raw),
        .q     (row_sync)
    );

    // Next column, dwell count and output qualification; hold wins over terminal count.
    always_comb begin
        advance     = (cnt_q >= TERM_CNT) && !kif.button_pressed;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (advance) begin
            state_d = col_state_e'(state_q + 2'd1);
            cnt_d   = '0;
        end else if (cnt_q < TERM_CNT) begin
            cnt_d   = cnt_q + 1'b1;
        end
        col_drive_d = col_onehot(state_d);
        col_idx_d   = state_d;
        qual_d      = (cnt_d >= SETTLE);
    end

    // Column FSM, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= COL0;
            cnt_q       <= '0;
            col_drive_q <= 4'b0001;
            col_idx_q   <= 2'd0;
            qual_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_drive_q <= col_drive_d;
            col_idx_q   <= col_idx_d;
            qual_q      <= qual_d;
        end
    end

    assign kif.col_drive  = col_drive_q;
    assign kif.col_idx    = col_idx_q;
    // Blank the first two dwell cycles so rows latched under the previous column never leak out.
    assign kif.q_row_keys = row_sync & {4{qual_q}};

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    localparam int SCAN_DIV = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    // Reference model: current column, cycles spent in it, recent row samples.
    int         m_col;
    int         m_cnt;
    logic [3:0] m_rows [$];

    typedef struct {
        logic [3:0] row;
        logic       bp;
        logic [3:0] cd;
        logic [1:0] idx;
        logic [3:0] q;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_col = 0;
        m_cnt = 0;
        m_rows.delete();
    endfunction

    function automatic void model_edge(logic [3:0] row, logic bp);
        m_rows.push_back(row);
        if (m_rows.size() > 2) void'(m_rows.pop_front());
        if (m_cnt >= SCAN_DIV - 1 && !bp) begin
            m_col = (m_col + 1) % 4;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic check_model();
        logic [3:0] exp_cd;
        logic [3:0] exp_q;
        exp_cd = 4'b0001 << m_col;
        exp_q  = (m_cnt >= 2 && m_rows.size() == 2) ? m_rows[0] : 4'b0000;
        chk("model_col_drive", 32'(kif.col_drive), 32'(exp_cd));
        chk("model_col_idx", 32'(kif.col_idx), 32'(m_col));
        chk("model_q_row_keys", 32'(kif.q_row_keys), 32'(exp_q));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(kif.row_raw, kif.button_pressed);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        kif.row_raw = 4'b0000;
        kif.button_pressed = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_col_drive", 32'(kif.col_drive), 32'h1);
        chk("reset_col_idx", 32'(kif.col_idx), 32'h0);
        chk("reset_q_row_keys", 32'(kif.q_row_keys), 32'h0);
        reset = 1'b1;
        model_reset();
    endtask

    // Outputs may only move on a rising clock edge (posedges fall at 5, 15, 25 ...).
    always @(kif.q_row_keys) begin
        if (mon_en) chk("q_change_on_edge", 32'($time % 10), 32'd5);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Free-run with a key on row 2 while column 2 is driven (entry k = edge k+1).
        for (int i = 0; i < 17; i++) begin
            tbl[i] = '{row: 4'b0000, bp: 1'b0, cd: 4'b0001, idx: 2'd0, q: 4'b0000};
        end
        for (int i = 4; i < 9; i++)   begin tbl[i].cd = 4'b0010; tbl[i].idx = 2'd1; end
        for (int i = 9; i < 14; i++)  begin tbl[i].cd = 4'b0100; tbl[i].idx = 2'd2; tbl[i].row = 4'b0100; end
        for (int i = 11; i < 14; i++) tbl[i].q = 4'b0100;
        for (int i = 14; i < 17; i++) begin tbl[i].cd = 4'b1000; tbl[i].idx = 2'd3; end

        do_reset();
        #1;
        for (int i = 0; i < 17; i++) begin
            kif.row_raw = tbl[i].row;
            kif.button_pressed = tbl[i].bp;
            tick();
            chk($sformatf("tbl%0d_col_drive", i), 32'(kif.col_drive), 32'(tbl[i].cd));
            chk($sformatf("tbl%0d_col_idx", i), 32'(kif.col_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl%0d_q", i), 32'(kif.q_row_keys), 32'(tbl[i].q));
        end

        // Hold in COL1 from counter 1 for 20 cycles, then release.
        do_reset();
        #1;
        repeat (6) tick();
        kif.button_pressed = 1'b1;
        repeat (20) begin
            tick();
            chk("hold_col_drive", 32'(kif.col_drive), 32'h2);
        end
        kif.button_pressed = 1'b0;
        tick();
        chk("hold_release_col2", 32'(kif.col_drive), 32'h4);

        // Button rises in the COL3 terminal-count cycle: no wrap until release.
        for (int i = 0; i < 40 && !(m_col == 3 && m_cnt == SCAN_DIV - 1); i++) tick();
        chk("term_cnt_in_col3", 32'(kif.col_drive), 32'h8);
        kif.button_pressed = 1'b1;
        repeat (7) begin
            tick();
            chk("simul_hold_col3", 32'(kif.col_drive), 32'h8);
        end
        kif.button_pressed = 1'b0;
        tick();
        chk("simul_release_wrap", 32'(kif.col_drive), 32'h1);

        // Reset asserted mid-cycle during a hold in COL2.
        for (int i = 0; i < 40 && m_col != 2; i++) tick();
        kif.button_pressed = 1'b1;
        repeat (3) tick();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_col_drive", 32'(kif.col_drive), 32'h1);
        chk("midrst_col_idx", 32'(kif.col_idx), 32'h0);
        chk("midrst_q", 32'(kif.q_row_keys), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        kif.button_pressed = 1'b0;
        reset = 1'b1;
        model_reset();
        k = 11;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (kif.col_drive == 4'b0010) begin
                k = e;
                break;
            end
        end
        chk("midrst_first_advance_edge", 32'(k), 32'(SCAN_DIV));

        // Randomized rows changing between edges and random holds.
        mon_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if ($urandom_range(0, 7) == 0) kif.button_pressed = ~kif.button_pressed;
            #($urandom_range(1, 7));
            kif.row_raw = 4'($urandom);
        end
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
